// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: arbitrates, latches the
// winner's operation, and returns the registered result with a one-cycle done pulse.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [2:0]       op0,
    input  logic [2:0]       op1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic [1:0]       fsm_state
);

    // Handshake: a requester holds req and its op/operands stable until it sees its
    // gnt; dropping req earlier withdraws it. done marks result/zero valid for one cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    logic   last_served;

    assign fsm_state = state;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state       <= IDLE;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            result      <= '0;
            zero        <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= 3'b000;
            last_served <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    // On a tie the requester not served last wins; last_served also
                    // records the current winner for steering done in EXEC.
                    if (req0 && (!req1 || last_served)) begin
                        alu_op      <= op0;
                        alu_a       <= a0;
                        alu_b       <= b0;
                        gnt0        <= 1'b1;
                        last_served <= 1'b0;
                        state       <= EXEC;
                    end else if (req1) begin
                        alu_op      <= op1;
                        alu_a       <= a1;
                        alu_b       <= b1;
                        gnt1        <= 1'b1;
                        last_served <= 1'b1;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    result <= alu_result;
                    zero   <= alu_zero;
                    gnt0   <= 1'b0;
                    gnt1   <= 1'b0;
                    done0  <= ~last_served;
                    done1  <= last_served;
                    state  <= DONE;
                end
                DONE: begin
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a local ALU model: arbitration, latency,
// latching, withdrawal, mid-operation reset and continuous-request throughput.
module tb_alu_arbiter;

    localparam int W = 32;

    logic          CLK = 1'b0;
    logic          Reset = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [2:0]    op0 = '0, op1 = '0;
    logic [W-1:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic          gnt0, gnt1, done0, done1, zero, alu_zero;
    logic [W-1:0]  result, alu_a, alu_b, alu_result;
    logic [2:0]    alu_op;
    logic [1:0]    fsm_state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    alu_arbiter #(.WIDTH(W)) dut (
        .CLK(CLK), .Reset(Reset),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .result(result), .zero(zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .fsm_state(fsm_state)
    );

    // ALU: add, sub, sltu, slt, and, or, sll, xor
    always_comb begin
        alu_result = '0;
        case (alu_op)
            3'b000: alu_result = alu_a + alu_b;
            3'b001: alu_result = alu_a - alu_b;
            3'b010: alu_result = {31'd0, alu_a < alu_b};
            3'b011: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            3'b100: alu_result = alu_a & alu_b;
            3'b101: alu_result = alu_a | alu_b;
            3'b110: alu_result = alu_a << alu_b[4:0];
            default: alu_result = alu_a ^ alu_b;
        endcase
    end
    assign alu_zero = (alu_result == '0);

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        req0 = 1'b0;
        req1 = 1'b0;
        Reset = 1'b0;
        tick();
        tick();
        Reset = 1'b1;
    endtask

    // Request, wait (bounded) for the grant, drop req, then step into the DONE cycle.
    task automatic do_op(input int who, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        bit seen = 0;
        if (who == 0) begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
        else          begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            seen = (who == 0) ? gnt0 : gnt1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL do_op_grant: requester %0d no grant within 8 cycles", who);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({gnt0, gnt1, done0, done1, zero, fsm_state} !== 7'b0 || result !== '0 ||
            alu_a !== '0 || alu_b !== '0 || alu_op !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_state: gnt=%b%b done=%b%b zero=%b st=%0d res=%h a=%h b=%h op=%b, want all 0",
                     gnt0, gnt1, done0, done1, zero, fsm_state, result, alu_a, alu_b, alu_op);
        end
    endtask

    task automatic test_single_req0();
        req0 = 1'b1; op0 = 3'b000; a0 = 32'd5; b0 = 32'd3;
        tick();
        req0 = 1'b0;
        n_checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || done0 !== 1'b0 || fsm_state !== 2'd1 ||
            alu_a !== 32'd5 || alu_b !== 32'd3 || alu_op !== 3'b000) begin
            n_fail++;
            $display("FAIL add_grant: gnt0=%b gnt1=%b done0=%b st=%0d a=%h b=%h op=%b, want 1 0 0 1 5 3 000",
                     gnt0, gnt1, done0, fsm_state, alu_a, alu_b, alu_op);
        end
        tick();
        n_checks++;
        if (done0 !== 1'b1 || done1 !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0 ||
            result !== 32'd8 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL add_done: done0=%b done1=%b gnt=%b%b result=%h zero=%b, want 1 0 00 8 0",
                     done0, done1, gnt0, gnt1, result, zero);
        end
        tick();
        n_checks++;
        if (done0 !== 1'b0 || fsm_state !== 2'd0 || result !== 32'd8) begin
            n_fail++;
            $display("FAIL add_after: done0=%b st=%0d result=%h, want 0 0 8", done0, fsm_state, result);
        end
    endtask

    task automatic test_req1_ops();
        do_op(1, 3'b001, 32'd7, 32'd7);
        n_checks++;
        if (done1 !== 1'b1 || done0 !== 1'b0 || result !== 32'd0 || zero !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_zero: done1=%b done0=%b result=%h zero=%b, want 1 0 0 1",
                     done1, done0, result, zero);
        end
        tick();
        do_op(1, 3'b011, 32'hFFFF_FFFF, 32'd1);
        n_checks++;
        if (done1 !== 1'b1 || result !== 32'd1 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL slt_signed: done1=%b result=%h zero=%b, want 1 1 0", done1, result, zero);
        end
        tick();
        do_op(1, 3'b010, 32'hFFFF_FFFF, 32'd1);
        n_checks++;
        if (done1 !== 1'b1 || result !== 32'd0 || zero !== 1'b1) begin
            n_fail++;
            $display("FAIL sltu: done1=%b result=%h zero=%b, want 1 0 1", done1, result, zero);
        end
        tick();
    endtask

    // Both requesters held: grants every 3 cycles alternating 0,1,0,1 from reset.
    task automatic test_contention();
        logic eg0, eg1, ed0, ed1;
        logic [W-1:0] er;
        int who;
        apply_reset();
        req0 = 1'b1; op0 = 3'b000; a0 = 32'd1;    b0 = 32'd1;
        req1 = 1'b1; op1 = 3'b101; a1 = 32'hF0;   b1 = 32'h0F;
        for (int k = 0; k < 12; k++) begin
            tick();
            who = (k / 3) % 2;
            eg0 = (k % 3 == 0) && (who == 0);
            eg1 = (k % 3 == 0) && (who == 1);
            ed0 = (k % 3 == 1) && (who == 0);
            ed1 = (k % 3 == 1) && (who == 1);
            er  = (who == 0) ? 32'd2 : 32'hFF;
            n_checks++;
            if ({gnt0, gnt1, done0, done1} !== {eg0, eg1, ed0, ed1} ||
                (k % 3 == 1 && result !== er)) begin
                n_fail++;
                $display("FAIL contention k=%0d: gnt=%b%b done=%b%b result=%h, want gnt=%b%b done=%b%b result=%h",
                         k, gnt0, gnt1, done0, done1, result, eg0, eg1, ed0, ed1, er);
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
    endtask

    task automatic test_latch_and_withdraw();
        req0 = 1'b1; op0 = 3'b000; a0 = 32'd10; b0 = 32'd20;
        tick();
        req0 = 1'b0; op0 = 3'b111; a0 = 32'hDEAD_BEEF; b0 = 32'h1234_5678;
        req1 = 1'b1; op1 = 3'b000; a1 = 32'd1; b1 = 32'd1;
        n_checks++;
        if (gnt0 !== 1'b1) begin
            n_fail++;
            $display("FAIL latch_grant: gnt0=%b, want 1", gnt0);
        end
        tick();
        req1 = 1'b0;
        n_checks++;
        if (done0 !== 1'b1 || result !== 32'd30 || alu_a !== 32'd10 || alu_op !== 3'b000) begin
            n_fail++;
            $display("FAIL latch_result: done0=%b result=%h alu_a=%h op=%b, want 1 1e a 000",
                     done0, result, alu_a, alu_op);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if (gnt1 !== 1'b0 || done1 !== 1'b0 || gnt0 !== 1'b0 || fsm_state !== 2'd0) begin
                n_fail++;
                $display("FAIL withdraw k=%0d: gnt1=%b done1=%b gnt0=%b st=%0d, want 0 0 0 0",
                         k, gnt1, done1, gnt0, fsm_state);
            end
        end
    endtask

    task automatic test_reset_mid_exec();
        req0 = 1'b1; op0 = 3'b000; a0 = 32'd2; b0 = 32'd3;
        tick();
        req0 = 1'b0;
        n_checks++;
        if (gnt0 !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_grant: gnt0=%b, want 1", gnt0);
        end
        #1 Reset = 1'b0;
        #1;
        n_checks++;
        if (gnt0 !== 1'b0 || done0 !== 1'b0 || result !== '0 || zero !== 1'b0 ||
            alu_a !== '0 || alu_b !== '0 || fsm_state !== 2'd0) begin
            n_fail++;
            $display("FAIL midrst_async: gnt0=%b done0=%b result=%h zero=%b a=%h b=%h st=%0d, want all 0",
                     gnt0, done0, result, zero, alu_a, alu_b, fsm_state);
        end
        #1 Reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (done0 !== 1'b0 || gnt0 !== 1'b0 || result !== '0) begin
                n_fail++;
                $display("FAIL midrst_discard k=%0d: done0=%b gnt0=%b result=%h, want 0 0 0",
                         k, done0, gnt0, result);
            end
        end
        do_op(0, 3'b000, 32'd4, 32'd4);
        n_checks++;
        if (done0 !== 1'b1 || result !== 32'd8 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_recover: done0=%b result=%h zero=%b, want 1 8 0", done0, result, zero);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic eg, ed;
        req0 = 1'b1; op0 = 3'b110; a0 = 32'd1; b0 = 32'd4;
        for (int k = 0; k < 12; k++) begin
            tick();
            eg = (k % 3 == 0);
            ed = (k % 3 == 1);
            n_checks++;
            if (gnt0 !== eg || done0 !== ed || gnt1 !== 1'b0 || done1 !== 1'b0 ||
                ((gnt0 | gnt1) & (done0 | done1)) !== 1'b0 || (ed && result !== 32'd16)) begin
                n_fail++;
                $display("FAIL back_to_back k=%0d: gnt=%b%b done=%b%b result=%h, want gnt0=%b done0=%b result=10",
                         k, gnt0, gnt1, done0, done1, result, eg, ed);
            end
        end
        req0 = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_req0();
        test_req1_ops();
        test_contention();
        test_latch_and_withdraw();
        test_reset_mid_exec();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
